// File: rtl/fftgen_fp_pkg.sv
// ---------------------------------------------------------------------------
// fftgen_fp_pkg : single-precision field constants shared by the FFT FP blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fftgen_fp_pkg;
  typedef logic [31:0] sp_float_t;

  localparam int FP_SIGN    = 31;
  localparam int FP_EXP_HI  = 30;
  localparam int FP_EXP_LO  = 23;
  localparam int FP_MANT_HI = 22;

  localparam sp_float_t FP_ZERO = 32'h0000_0000;
  localparam sp_float_t FP_NAN  = 32'hFFFF_FFFF;
endpackage

`default_nettype wire

// File: rtl/fp_add_sched_if.sv
// ---------------------------------------------------------------------------
// fp_add_sched_if : requester and result handshake bundle for fp_add_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fp_add_sched_if
  import fftgen_fp_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  sp_float_t          res_z;
  logic [IDW-1:0]     res_id;
  logic               res_err;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_z, res_id, res_err
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_z, res_id, res_err
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : one-hot round-robin grant searching upward from ptr with wrap
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);
  int   w_idx;
  logic w_found;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (en && !w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_id     = IDW'(w_idx);
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/sradd.sv
// ---------------------------------------------------------------------------
// sradd : combinational same-sign SP adder (truncating, x+0 = x)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sradd
  import fftgen_fp_pkg::*;
(
  input  sp_float_t a,
  input  sp_float_t b,
  output sp_float_t z
);
  logic [7:0]  w_e_big;
  logic [7:0]  w_e_diff;
  logic [23:0] w_m_big;
  logic [23:0] w_m_small;
  logic [24:0] w_sum;
  logic        w_a_big;

  always_comb begin
    w_a_big   = (a[FP_EXP_HI:FP_EXP_LO] >= b[FP_EXP_HI:FP_EXP_LO]);
    w_e_big   = w_a_big ? a[FP_EXP_HI:FP_EXP_LO] : b[FP_EXP_HI:FP_EXP_LO];
    w_e_diff  = w_a_big ? (a[FP_EXP_HI:FP_EXP_LO] - b[FP_EXP_HI:FP_EXP_LO])
                        : (b[FP_EXP_HI:FP_EXP_LO] - a[FP_EXP_HI:FP_EXP_LO]);
    w_m_big   = w_a_big ? {|a[FP_EXP_HI:FP_EXP_LO], a[FP_MANT_HI:0]}
                        : {|b[FP_EXP_HI:FP_EXP_LO], b[FP_MANT_HI:0]};
    w_m_small = w_a_big ? {|b[FP_EXP_HI:FP_EXP_LO], b[FP_MANT_HI:0]}
                        : {|a[FP_EXP_HI:FP_EXP_LO], a[FP_MANT_HI:0]};
    w_m_small = (w_e_diff > 8'd23) ? 24'd0 : (w_m_small >> w_e_diff);
    w_sum     = {1'b0, w_m_big} + {1'b0, w_m_small};
    // carry out of the hidden bit renormalises by one place
    if (w_sum[24]) begin
      z = {a[FP_SIGN], w_e_big + 8'd1, w_sum[23:1]};
    end else begin
      z = {a[FP_SIGN], w_e_big, w_sum[22:0]};
    end
    if (a == FP_ZERO) begin
      z = b;
    end else if (b == FP_ZERO) begin
      z = a;
    end
  end
endmodule

`default_nettype wire

// File: rtl/fp_add_sched.sv
// ---------------------------------------------------------------------------
// fp_add_sched : round-robin scheduler sharing one SP adder, 2-stage pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_add_sched
  import fftgen_fp_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  fp_add_sched_if.slave   bus
);
  localparam int IDW = $clog2(NREQ);

  logic           r_s1_valid;
  sp_float_t      r_s1_a;
  sp_float_t      r_s1_b;
  logic [IDW-1:0] r_s1_id;
  logic           r_s2_valid;
  sp_float_t      r_s2_z;
  logic [IDW-1:0] r_s2_id;
  logic           r_s2_err;
  logic [IDW-1:0] r_rr_ptr;

  logic           w_s2_adv;
  logic           w_s1_adv;
  logic           w_arb_en;
  logic           w_accept;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW-1:0] w_next_ptr;
  sp_float_t      w_sel_a;
  sp_float_t      w_sel_b;
  sp_float_t      w_sum;
  logic           w_err;

  assign w_s2_adv = !r_s2_valid || bus.res_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  // no grant may be offered while reset holds the pipeline empty
  assign w_arb_en = w_s1_adv && !rst;
  assign w_accept = w_arb_en && (|bus.req_valid);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (r_rr_ptr),
    .en     (w_arb_en),
    .gnt    (bus.req_ready),
    .gnt_id (w_gnt_id)
  );

  assign w_sel_a    = bus.req_a[{w_gnt_id, 5'd0} +: 32];
  assign w_sel_b    = bus.req_b[{w_gnt_id, 5'd0} +: 32];
  assign w_next_ptr = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;

  sradd u_sradd (
    .a (r_s1_a),
    .b (r_s1_b),
    .z (w_sum)
  );

  assign w_err = (r_s1_a[FP_SIGN] != r_s1_b[FP_SIGN]) &&
                 (r_s1_a != FP_ZERO) && (r_s1_b != FP_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= FP_ZERO;
      r_s1_b     <= FP_ZERO;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_z     <= FP_ZERO;
      r_s2_id    <= '0;
      r_s2_err   <= 1'b0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_a  <= w_sel_a;
          r_s1_b  <= w_sel_b;
          r_s1_id <= w_gnt_id;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_z   <= w_err ? FP_NAN : w_sum;
          r_s2_id  <= r_s1_id;
          r_s2_err <= w_err;
        end
      end
      if (w_accept) begin
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign bus.res_valid = r_s2_valid;
  assign bus.res_z     = r_s2_z;
  assign bus.res_id    = r_s2_id;
  assign bus.res_err   = r_s2_err;
endmodule

`default_nettype wire

// File: tb/tb_fp_add_sched.sv
// ---------------------------------------------------------------------------
// tb_fp_add_sched : directed vector bench for fp_add_sched (NREQ = 4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_add_sched;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fp_add_sched_if #(.NREQ(4)) bus ();

  fp_add_sched #(.NREQ(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        err;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] t_a[4];
  logic [31:0] t_b[4];
  logic [31:0] t_z[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*id +: 32] = a;
    bus.req_b[32*id +: 32] = b;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;

    vecs[0] = '{0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0};
    vecs[1] = '{2, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0};
    vecs[2] = '{2, 32'h00000000, 32'h40490FDB, 32'h40490FDB, 1'b0};
    vecs[3] = '{1, 32'h3F800000, 32'hBF800000, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{1, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0};
    vecs[5] = '{3, 32'h40490FDB, 32'h00000000, 32'h40490FDB, 1'b0};
    vecs[6] = '{0, 32'hBF800000, 32'hBF800000, 32'hC0000000, 1'b0};
    vecs[7] = '{3, 32'h80000000, 32'h3F800000, 32'hFFFFFFFF, 1'b1};
    vecs[8] = '{1, 32'h00000000, 32'hBF800000, 32'hBF800000, 1'b0};

    t_a = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    t_b = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h00000000};
    t_z = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000};

    // reset state, with every requester asking for service
    bus.req_valid = 4'hF;
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_res_z",     bus.res_z,          32'h0);
    chk("rst_res_id",    32'(bus.res_id),    32'h0);
    chk("rst_res_err",   32'(bus.res_err),   32'h0);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single-requester vectors: grant, 2-cycle latency, result fields
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].id, vecs[i].a, vecs[i].b);
      bus.req_valid = 4'(1 << vecs[i].id);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(1 << vecs[i].id));
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      @(negedge clk);
      chk($sformatf("v%0d_early", i), 32'(bus.res_valid), 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(bus.res_valid), 32'h1);
      chk($sformatf("v%0d_z", i),     bus.res_z,          vecs[i].z);
      chk($sformatf("v%0d_id", i),    32'(bus.res_id),    32'(vecs[i].id));
      chk($sformatf("v%0d_err", i),   32'(bus.res_err),   32'(vecs[i].err));
    end

    // all four requesters continuously valid, consumer always ready
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, t_a[i], t_b[i]);
    bus.req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("rr_ready_c%0d", c), 32'(bus.req_ready),
          (c < 8) ? 32'(1 << (c % 4)) : 32'h0);
      if (c >= 2) begin
        chk($sformatf("rr_valid_c%0d", c), 32'(bus.res_valid), 32'h1);
        chk($sformatf("rr_id_c%0d", c),    32'(bus.res_id),    32'((c - 2) % 4));
        chk($sformatf("rr_z_c%0d", c),     bus.res_z,          t_z[(c - 2) % 4]);
      end else begin
        chk($sformatf("rr_valid_c%0d", c), 32'(bus.res_valid), 32'h0);
      end
      if (c == 7) begin
        @(posedge clk);
        #1;
        bus.req_valid = '0;
      end
    end

    // back-pressure: consumer stalls for 5 cycles after the first result
    do_reset();
    bus.req_valid = 4'hF;
    @(negedge clk);
    chk("st_ready0", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk("st_ready1", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    chk("st_first_valid", 32'(bus.res_valid), 32'h1);
    chk("st_first_id",    32'(bus.res_id),    32'h0);
    bus.res_ready = 1'b0;
    #1;
    chk("st_ready_drop", 32'(bus.req_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("st_hold_valid%0d", k), 32'(bus.res_valid), 32'h1);
      chk($sformatf("st_hold_id%0d", k),    32'(bus.res_id),    32'h0);
      chk($sformatf("st_hold_z%0d", k),     bus.res_z,          t_z[0]);
      chk($sformatf("st_hold_ready%0d", k), 32'(bus.req_ready), 32'h0);
    end
    bus.res_ready = 1'b1;
    #1;
    chk("st_resume_ready", 32'(bus.req_ready), 32'h4);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("st_res_valid%0d", k), 32'(bus.res_valid), 32'h1);
      chk($sformatf("st_res_id%0d", k),    32'(bus.res_id),    32'(k % 4));
      chk($sformatf("st_res_z%0d", k),     bus.res_z,          t_z[k % 4]);
      if (k == 6) bus.req_valid = '0;
    end
    @(negedge clk);
    chk("st_no_dup", 32'(bus.res_valid), 32'h0);

    // reset with both stages full; pointer must return to 0
    do_reset();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0011;
    @(negedge clk);
    chk("rf_ready0", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk("rf_ready1", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    chk("rf_full_valid", 32'(bus.res_valid), 32'h1);
    chk("rf_full_ready", 32'(bus.req_ready), 32'h0);
    rst = 1'b1;
    #1;
    chk("rf_async_valid", 32'(bus.res_valid), 32'h0);
    chk("rf_async_z",     bus.res_z,          32'h0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("rf_ptr_grant", 32'(bus.req_ready), 32'h2);
    chk("rf_no_stale",  32'(bus.res_valid), 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("rf_no_stale2", 32'(bus.res_valid), 32'h0);
    @(negedge clk);
    chk("rf_new_valid", 32'(bus.res_valid), 32'h1);
    chk("rf_new_id",    32'(bus.res_id),    32'h1);
    chk("rf_new_z",     bus.res_z,          t_z[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
